// File: rtl/ocx_tlx_data_frame_buf.sv
// Commit/rewind holding buffer for parsed TLX data flits; flits become readable only after their bookend.
// Optional statistics counters are built when OCX_TLX_DATA_BUF_STATS_EN is defined.
module ocx_tlx_data_frame_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          tlx_clk,
  input  logic          reset,
  input  logic [511:0]  pars_data_flit,
  input  logic          pars_data_valid,
  input  logic          bookend_flit_v,
  input  logic [7:0]    bad_data_indicator,
  input  logic          crc_error,
  output logic [511:0]  data_out,
  output logic          data_out_bad,
  output logic          data_out_valid,
  input  logic          data_out_ready,
  output logic [AW:0]   buf_free,
  output logic          overflow_err,
  output logic          frame_err,
  output logic [15:0]   stat_frames,
  output logic [15:0]   stat_discards
);

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      cm_ptr_reg, cm_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [511:0]     mem [DEPTH];
  logic [DEPTH-1:0] bad_reg, bad_next;
  logic             overflow_reg, frame_err_reg;

  logic [AW:0] pending;
  logic [AW:0] occupancy;
  logic        full;
  logic        wr_en;
  logic        rd_en;

  assign pending   = wr_ptr_reg - cm_ptr_reg;
  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign full      = (occupancy == DEPTH_P);
  assign wr_en     = pars_data_valid && !full;
  assign rd_en     = data_out_valid && data_out_ready;

  // Commit moves cm_ptr to the pre-write wr_ptr, so a same-cycle rewind also drops the same-cycle write.
  always_comb begin
    cm_ptr_next = cm_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (bookend_flit_v)
      cm_ptr_next = wr_ptr_reg;
    if (crc_error)
      wr_ptr_next = cm_ptr_next;
    else if (wr_en)
      wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_en)
      rd_ptr_next = rd_ptr_reg + 1'b1;
  end

  always_ff @(posedge tlx_clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      cm_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      cm_ptr_reg <= cm_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (pars_data_valid && full)
        overflow_reg <= 1'b1;
      if (bookend_flit_v && (pending > (AW+1)'(8)))
        frame_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge tlx_clk) begin
    if (wr_en)
      mem[wr_ptr_reg[AW-1:0]] <= pars_data_flit;
  end

  // Per-entry bad bit: a fresh write clears it, a commit tags entries by their age within the pending run.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bad
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic [AW-1:0] off;
      logic          covered;
      assign off     = IDX - cm_ptr_reg[AW-1:0];
      assign covered = bookend_flit_v && ({1'b0, off} < pending);
      always_comb begin
        bad_next[gi] = bad_reg[gi];
        if (wr_en && (wr_ptr_reg[AW-1:0] == IDX))
          bad_next[gi] = 1'b0;
        else if (covered)
          bad_next[gi] = (off < AW'(8)) ? bad_data_indicator[off[2:0]] : 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge tlx_clk) begin
    if (reset)
      bad_reg <= '0;
    else
      bad_reg <= bad_next;
  end

  assign data_out_valid = (rd_ptr_reg != cm_ptr_reg);
  assign data_out       = data_out_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;
  assign data_out_bad   = data_out_valid ? bad_reg[rd_ptr_reg[AW-1:0]] : 1'b0;
  assign buf_free       = DEPTH_P - occupancy;
  assign overflow_err   = overflow_reg;
  assign frame_err      = frame_err_reg;

`ifdef OCX_TLX_DATA_BUF_STATS_EN
  logic [15:0] frames_reg, discards_reg;
  logic [16:0] disc_amt;
  logic [16:0] disc_sum;

  // Rewind discards the pending run (empty after a same-cycle commit) plus any accepted same-cycle write.
  assign disc_amt = crc_error ? (17'(bookend_flit_v ? '0 : pending) + 17'(wr_en)) : 17'd0;
  assign disc_sum = {1'b0, discards_reg} + disc_amt;

  always_ff @(posedge tlx_clk) begin
    if (reset) begin
      frames_reg   <= '0;
      discards_reg <= '0;
    end else begin
      if (bookend_flit_v && (frames_reg != 16'hFFFF))
        frames_reg <= frames_reg + 16'd1;
      discards_reg <= disc_sum[16] ? 16'hFFFF : disc_sum[15:0];
    end
  end

  assign stat_frames   = frames_reg;
  assign stat_discards = discards_reg;
`else
  assign stat_frames   = 16'h0000;
  assign stat_discards = 16'h0000;
`endif

endmodule

// File: tb/tb_ocx_tlx_data_frame_buf.sv
// Randomized and directed bench for ocx_tlx_data_frame_buf against a queue-based frame model.
module tb_ocx_tlx_data_frame_buf;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] pars_data_flit = '0;
  logic         pars_data_valid = 1'b0;
  logic         bookend_flit_v = 1'b0;
  logic [7:0]   bad_data_indicator = '0;
  logic         crc_error = 1'b0;
  logic [511:0] data_out;
  logic         data_out_bad;
  logic         data_out_valid;
  logic         data_out_ready = 1'b0;
  logic [AW:0]  buf_free;
  logic         overflow_err;
  logic         frame_err;
  logic [15:0]  stat_frames;
  logic [15:0]  stat_discards;

  ocx_tlx_data_frame_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .tlx_clk(clk), .reset(reset), .pars_data_flit(pars_data_flit),
    .pars_data_valid(pars_data_valid), .bookend_flit_v(bookend_flit_v),
    .bad_data_indicator(bad_data_indicator), .crc_error(crc_error),
    .data_out(data_out), .data_out_bad(data_out_bad), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .buf_free(buf_free), .overflow_err(overflow_err),
    .frame_err(frame_err), .stat_frames(stat_frames), .stat_discards(stat_discards)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic         b;
  } ent_t;

  ent_t         cq[$];
  logic [511:0] pq[$];
  int           m_frames, m_disc;
  bit           m_ovf, m_ferr;
  int           total = 0;
  int           bad = 0;

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_fr, exp_di;
    chk({tag, ":valid"}, 512'(data_out_valid), 512'(cq.size() != 0));
    if (cq.size() != 0) begin
      chk({tag, ":data"}, data_out, cq[0].d);
      chk({tag, ":bad"}, 512'(data_out_bad), 512'(cq[0].b));
    end else begin
      chk({tag, ":data0"}, data_out, '0);
      chk({tag, ":bad0"}, 512'(data_out_bad), 512'(0));
    end
    chk({tag, ":free"}, 512'(buf_free), 512'(DEPTH - cq.size() - pq.size()));
    chk({tag, ":ovf"}, 512'(overflow_err), 512'(m_ovf));
    chk({tag, ":ferr"}, 512'(frame_err), 512'(m_ferr));
`ifdef OCX_TLX_DATA_BUF_STATS_EN
    exp_fr = m_frames;
    exp_di = m_disc;
`else
    exp_fr = 0;
    exp_di = 0;
`endif
    chk({tag, ":frames"}, 512'(stat_frames), 512'(exp_fr));
    chk({tag, ":discards"}, 512'(stat_discards), 512'(exp_di));
  endtask

  // One clock: check current outputs, drive inputs, advance the model, clock.
  task automatic step(input string tag, input logic v, input logic [511:0] f, input logic bk,
                      input logic [7:0] m, input logic crc, input logic rdy);
    int occ;
    check_all(tag);
    $display("txn %s wr=%0b bk=%0b mask=%02h crc=%0b rdy=%0b occ=%0d", tag, v, bk, m, crc, rdy,
             cq.size() + pq.size());
    pars_data_valid = v; pars_data_flit = f; bookend_flit_v = bk;
    bad_data_indicator = m; crc_error = crc; data_out_ready = rdy;
    occ = cq.size() + pq.size();
    if (rdy && cq.size() != 0) void'(cq.pop_front());
    if (bk) begin
      if (pq.size() > 8) m_ferr = 1;
      for (int i = 0; i < pq.size(); i++) begin
        ent_t e;
        e.d = pq[i];
        e.b = (i < 8) ? m[i] : 1'b1;
        cq.push_back(e);
      end
      pq.delete();
      if (m_frames < 65535) m_frames++;
    end
    if (v) begin
      if (occ == DEPTH) m_ovf = 1;
      else pq.push_back(f);
    end
    if (crc) begin
      m_disc = (m_disc + pq.size() > 65535) ? 65535 : m_disc + pq.size();
      pq.delete();
    end
    @(posedge clk);
    #1;
    pars_data_valid = 0; bookend_flit_v = 0; crc_error = 0; bad_data_indicator = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    cq.delete(); pq.delete();
    m_frames = 0; m_disc = 0; m_ovf = 0; m_ferr = 0;
    $display("txn reset");
  endtask

  initial begin
    do_reset();
    check_all("reset");

    // Three flits, bookend mask 02, drained with ready high.
    for (int i = 0; i < 3; i++) step("wr3", 1, rnd512(), 0, 0, 0, 0);
    step("bk02", 0, '0, 1, 8'h02, 0, 0);
    for (int i = 0; i < 4; i++) step("drain3", 0, '0, 0, 0, 0, 1);

    // Rewind two flits, then a clean frame of two.
    for (int i = 0; i < 2; i++) step("wr_spec", 1, rnd512(), 0, 0, 0, 0);
    step("crc", 0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("wr_de", 1, rnd512(), 0, 0, 0, 0);
    step("bk00", 0, '0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step("drain_de", 0, '0, 0, 0, 0, 1);

    // Bookend + write + crc in one cycle.
    step("wr_x", 1, rnd512(), 0, 0, 0, 0);
    step("bk_wr_crc", 1, rnd512(), 1, 8'h01, 1, 0);
    for (int i = 0; i < 2; i++) step("drain_x", 0, '0, 0, 0, 0, 1);

    // Crc with a same-cycle write and no commit.
    step("wr_p", 1, rnd512(), 0, 0, 0, 0);
    step("wr_crc", 1, rnd512(), 0, 0, 1, 0);
    step("bk_empty", 0, '0, 1, 8'hFF, 0, 0);

    // Fill to full, overflow, drain across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, rnd512(), 0, 0, 0, 0);
    step("bk_full", 0, '0, 1, 8'hA5, 0, 0);
    step("ovf_wr", 1, rnd512(), 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step("drain_full", 0, '0, 0, 0, 0, 1);

    // Ten-flit frame exercises the over-long tagging.
    do_reset();
    for (int i = 0; i < 10; i++) step("wr10", 1, rnd512(), 0, 0, 0, 0);
    step("bkFF", 0, '0, 1, 8'hFF, 0, 0);
    for (int i = 0; i < 11; i++) step("drain10", 0, '0, 0, 0, 0, 1);

    // Reset with committed and pending data.
    for (int i = 0; i < 3; i++) step("wr_c", 1, rnd512(), 0, 0, 0, 0);
    step("bk_c", 0, '0, 1, 8'h05, 0, 0);
    for (int i = 0; i < 4; i++) step("wr_pend", 1, rnd512(), 0, 0, 0, 0);
    do_reset();
    check_all("mid_reset");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic v, bk, crc, rdy;
      v   = ($urandom_range(0, 2) != 0) && (cq.size() + pq.size() < DEPTH || $urandom_range(0, 9) == 0);
      bk  = ($urandom_range(0, 5) == 0);
      crc = ($urandom_range(0, 14) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      step("rand", v, rnd512(), bk, 8'($urandom), crc, rdy);
    end
    for (int i = 0; i < DEPTH + 2; i++) step("final_drain", 0, '0, 1, 8'($urandom), 0, 1);
    check_all("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
